// File: rtl/usb_sie_regs_pkg.sv
// ---------------------------------------------------------------------------
// usb_sie_regs_pkg
//   I/O address map and register layouts for the USB SIE register block.
//   - SIE_BASE_NIBBLE : io_addr[15:12] value that selects the SIE window
//   - REG_*           : word index (io_addr[11:1]) of each register
//   - *_BIT           : bit positions used by control writes / status reads
//   - tx_ctrl_t/rx_ctrl_t : low nibble of the TX/RX control status words
// ---------------------------------------------------------------------------
package usb_sie_regs_pkg;

    localparam logic [3:0]  SIE_BASE_NIBBLE = 4'h6;

    // Word indices; the byte offsets are 0x000, 0x002, 0x004, 0x006.
    localparam logic [10:0] REG_TX_DATA    = 11'd0;
    localparam logic [10:0] REG_TX_CONTROL = 11'd1;
    localparam logic [10:0] REG_RX_DATA    = 11'd2;
    localparam logic [10:0] REG_RX_CONTROL = 11'd3;

    // TX_CONTROL write bits
    localparam int TXC_GO_BIT  = 0;
    localparam int TXC_OVF_BIT = 1;

    // RX_CONTROL write-one-to-clear bits
    localparam int RXC_ROVF_BIT = 1;
    localparam int RXC_EOP_BIT  = 2;
    localparam int RXC_ERR_BIT  = 3;

    // FIFO count field starts here in both control status words
    localparam int CTRL_COUNT_LSB = 4;

    // Declared MSB first so that go lands on bit 0.
    typedef struct packed {
        logic empty;
        logic full;
        logic ovf;
        logic go;
    } tx_ctrl_t;

    typedef struct packed {
        logic err;
        logic eop;
        logic rovf;
        logic not_empty;
    } rx_ctrl_t;

    function automatic logic sie_selected(input logic [15:0] addr);
        return addr[15:12] == SIE_BASE_NIBBLE;
    endfunction

endpackage

// File: rtl/usb_byte_fifo.sv
// ---------------------------------------------------------------------------
// usb_byte_fifo
//   Small byte FIFO with a combinational head output. Storage is a register
//   array cleared by reset so the head reads 0 after reset.
//   Ports:
//     clk, reset        : clock, asynchronous active-high reset
//     push, push_data   : enqueue request and byte
//     pop               : dequeue request (ignored when empty)
//     head              : oldest byte (stale/zero when empty)
//     full, empty, count: occupancy status
//   A push while full is accepted only when a pop happens on the same edge;
//   the caller decides whether it wants to offer such a push.
// ---------------------------------------------------------------------------
module usb_byte_fifo #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic [7:0]    push_data,
    input  logic          pop,
    output logic [7:0]    head,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count
);

    logic [7:0]    mem_reg [DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [AW:0]   count_reg;
    logic [AW:0]   count_next;
    logic          do_push;
    logic          do_pop;

    assign full  = (count_reg == (AW+1)'(DEPTH));
    assign empty = (count_reg == '0);
    assign count = count_reg;
    assign head  = mem_reg[rd_ptr_reg];

    assign do_pop  = pop & ~empty;
    // When full, the slot being written is the head that leaves on this edge.
    assign do_push = push & (~full | do_pop);

    always_comb begin
        count_next = count_reg;
        case ({do_push, do_pop})
            2'b10:   count_next = count_reg + (AW+1)'(1);
            2'b01:   count_next = count_reg - (AW+1)'(1);
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_reg[i] <= 8'h00;
            end
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                mem_reg[wr_ptr_reg] <= push_data;
                wr_ptr_reg          <= wr_ptr_reg + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            count_reg <= count_next;
        end
    end

endmodule

// File: rtl/usb_sie_regs.sv
// ---------------------------------------------------------------------------
// usb_sie_regs
//   CPU register block for the USB serial interface engine at 16'h6000.
//   Ports:
//     clk, reset                  : clock, asynchronous active-high reset
//     io_addr/io_rd/io_wr/io_wdata: 16-bit I/O bus request
//     io_rdata                    : registered read data (1-cycle latency)
//     tx_data/tx_valid/tx_last    : byte stream to the SIE
//     tx_ready                    : SIE accepts the current TX byte
//     rx_data/rx_valid            : byte stream from the SIE
//     rx_eop/rx_err               : end-of-packet / error pulses
//   Registers (word index = io_addr[11:1]):
//     0 TX_DATA, 1 TX_CONTROL, 2 RX_DATA, 3 RX_CONTROL
// ---------------------------------------------------------------------------
module usb_sie_regs
    import usb_sie_regs_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] io_addr,
    input  logic        io_rd,
    input  logic        io_wr,
    input  logic [15:0] io_wdata,
    output logic [15:0] io_rdata,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    output logic        tx_last,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    input  logic        rx_eop,
    input  logic        rx_err
);

    // ---------------- decode ----------------
    logic        sel;
    logic [10:0] reg_idx;
    logic        wr_en;
    logic        rd_en;
    logic        wr_tx_data;
    logic        wr_tx_ctrl;
    logic        wr_rx_ctrl;
    logic        rd_rx_data;
    logic        bus_unused;

    assign sel     = sie_selected(io_addr);
    assign reg_idx = io_addr[11:1];
    assign wr_en   = io_wr & sel;
    // A write wins over a simultaneous read: the read is dropped entirely.
    assign rd_en   = io_rd & ~io_wr;

    assign wr_tx_data = wr_en & (reg_idx == REG_TX_DATA);
    assign wr_tx_ctrl = wr_en & (reg_idx == REG_TX_CONTROL);
    assign wr_rx_ctrl = wr_en & (reg_idx == REG_RX_CONTROL);
    assign rd_rx_data = rd_en & sel & (reg_idx == REG_RX_DATA);

    assign bus_unused = io_addr[0] ^ (^io_wdata[15:8]);

    // ---------------- TX path ----------------
    logic [7:0]  tx_head;
    logic        tx_full;
    logic        tx_empty;
    logic [AW:0] tx_count;
    logic        tx_push;
    logic        tx_pop;
    logic        go_reg;
    logic        go_next;
    logic        ovf_reg;
    logic        ovf_next;
    logic        set_go;

    // A full TX FIFO drops the CPU write even if the SIE pops on this edge.
    assign tx_push = wr_tx_data & ~tx_full;
    assign tx_pop  = tx_valid & tx_ready;

    usb_byte_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_tx_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (tx_push),
        .push_data (io_wdata[7:0]),
        .pop       (tx_pop),
        .head      (tx_head),
        .full      (tx_full),
        .empty     (tx_empty),
        .count     (tx_count)
    );

    assign tx_valid = go_reg & ~tx_empty;
    assign tx_data  = tx_head;
    assign tx_last  = tx_valid & (tx_count == (AW+1)'(1));

    assign set_go = wr_tx_ctrl & io_wdata[TXC_GO_BIT] & ~tx_empty;

    always_comb begin
        // A fresh go request wins over the end-of-packet clear.
        go_next  = set_go | (go_reg & ~(tx_pop & tx_last));
        ovf_next = (ovf_reg & ~(wr_tx_ctrl & io_wdata[TXC_OVF_BIT]))
                 | (wr_tx_data & tx_full);
    end

    // ---------------- RX path ----------------
    logic [7:0]  rx_head;
    logic        rx_full;
    logic        rx_empty;
    logic [AW:0] rx_count;
    logic        rx_pop;
    logic        rovf_reg;
    logic        rovf_next;
    logic        eop_reg;
    logic        eop_next;
    logic        err_reg;
    logic        err_next;

    assign rx_pop = rd_rx_data & ~rx_empty;

    // The FIFO itself accepts a push into a full buffer when the CPU pops
    // on the same edge, so only a push without a pop overflows.
    usb_byte_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_rx_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (rx_valid),
        .push_data (rx_data),
        .pop       (rx_pop),
        .head      (rx_head),
        .full      (rx_full),
        .empty     (rx_empty),
        .count     (rx_count)
    );

    always_comb begin
        // Set terms are ORed in last so a same-cycle set beats the clear.
        rovf_next = (rovf_reg & ~(wr_rx_ctrl & io_wdata[RXC_ROVF_BIT]))
                  | (rx_valid & rx_full & ~rx_pop);
        eop_next  = (eop_reg & ~(wr_rx_ctrl & io_wdata[RXC_EOP_BIT])) | rx_eop;
        err_next  = (err_reg & ~(wr_rx_ctrl & io_wdata[RXC_ERR_BIT])) | rx_err;
    end

    // ---------------- read mux ----------------
    tx_ctrl_t    tx_stat;
    rx_ctrl_t    rx_stat;
    logic [15:0] tx_word;
    logic [15:0] rx_word;
    logic [15:0] rdata_reg;
    logic [15:0] rdata_next;

    always_comb begin
        tx_stat = '{empty: tx_empty, full: tx_full, ovf: ovf_reg, go: go_reg};
        rx_stat = '{err: err_reg, eop: eop_reg, rovf: rovf_reg, not_empty: ~rx_empty};

        tx_word = '0;
        tx_word[3:0] = tx_stat;
        tx_word[CTRL_COUNT_LSB +: AW+1] = tx_count;

        rx_word = '0;
        rx_word[3:0] = rx_stat;
        rx_word[CTRL_COUNT_LSB +: AW+1] = rx_count;

        rdata_next = rdata_reg;
        if (rd_en) begin
            rdata_next = '0;
            if (sel) begin
                case (reg_idx)
                    REG_TX_DATA:    rdata_next = '0;
                    REG_TX_CONTROL: rdata_next = tx_word;
                    REG_RX_DATA:    rdata_next = rx_empty ? 16'h0000 : {8'h00, rx_head};
                    REG_RX_CONTROL: rdata_next = rx_word;
                    default:        rdata_next = '0;
                endcase
            end
        end
    end

    assign io_rdata = rdata_reg;

    // ---------------- state registers ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata_reg <= '0;
            go_reg    <= 1'b0;
            ovf_reg   <= 1'b0;
            rovf_reg  <= 1'b0;
            eop_reg   <= 1'b0;
            err_reg   <= 1'b0;
        end else begin
            rdata_reg <= rdata_next;
            go_reg    <= go_next;
            ovf_reg   <= ovf_next;
            rovf_reg  <= rovf_next;
            eop_reg   <= eop_next;
            err_reg   <= err_next;
        end
    end

endmodule

// File: tb/tb_usb_sie_regs.sv
// ---------------------------------------------------------------------------
// tb_usb_sie_regs
//   Directed scenarios plus a randomized run for usb_sie_regs. A queue-based
//   model of the register block predicts tx_* outputs and io_rdata on every
//   clock; directed scenarios add fixed expected values on top.
// ---------------------------------------------------------------------------
module tb_usb_sie_regs;

    localparam int DEPTH = 4;
    localparam int AW    = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] io_addr;
    logic        io_rd;
    logic        io_wr;
    logic [15:0] io_wdata;
    logic [15:0] io_rdata;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_last;
    logic        tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_eop;
    logic        rx_err;

    always #5 clk = ~clk;

    usb_sie_regs #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk      (clk),
        .reset    (reset),
        .io_addr  (io_addr),
        .io_rd    (io_rd),
        .io_wr    (io_wr),
        .io_wdata (io_wdata),
        .io_rdata (io_rdata),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_last  (tx_last),
        .tx_ready (tx_ready),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_eop   (rx_eop),
        .rx_err   (rx_err)
    );

    int n_vec = 0;
    int n_err = 0;

    // ---------------- reference model state ----------------
    logic [7:0]  tx_q[$];
    logic [7:0]  rx_q[$];
    bit          m_go, m_ovf, m_rovf, m_eop, m_errf;
    logic [15:0] m_rdata;

    logic [15:0] addr_tab [10] = '{16'h6000, 16'h6002, 16'h6004, 16'h6006, 16'h6001,
                                   16'h6005, 16'h6008, 16'h601E, 16'h7002, 16'h2004};

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        tx_q.delete();
        rx_q.delete();
        m_go = 0; m_ovf = 0; m_rovf = 0; m_eop = 0; m_errf = 0;
        m_rdata = 16'h0000;
    endtask

    // One clock: check outputs of the current state, apply inputs, advance
    // the model, check the registered read data after the edge.
    task automatic step(input logic [15:0] a, input logic rd, input logic wr,
                        input logic [15:0] wd, input logic rdy, input logic [7:0] rxd,
                        input logic rxv, input logic eop, input logic err);
        bit sel, r, tv, tpop, tlast, tpush, setgo, rpop, rpush;
        int idx, txn, rxn;
        bit n_go, n_ovf, n_rovf, n_eop, n_errf;
        logic [15:0] nrd;

        txn = tx_q.size();
        rxn = rx_q.size();
        tv  = m_go && (txn > 0);
        check_eq("tx_valid", 16'(tx_valid), 16'(tv));
        check_eq("tx_last", 16'(tx_last), 16'(tv && txn == 1));
        if (tv) check_eq("tx_data", 16'(tx_data), 16'(tx_q[0]));

        io_addr = a; io_rd = rd; io_wr = wr; io_wdata = wd;
        tx_ready = rdy; rx_data = rxd; rx_valid = rxv; rx_eop = eop; rx_err = err;

        sel   = (a[15:12] == 4'h6);
        idx   = int'(a[11:1]);
        r     = rd && !wr;
        tpop  = tv && rdy;
        tlast = tv && (txn == 1);
        rpop  = 0;
        nrd   = m_rdata;
        if (r) begin
            nrd = 16'h0000;
            if (sel) begin
                if (idx == 1)
                    nrd = 16'(txn * 16 + (txn == 0 ? 8 : 0) + (txn == DEPTH ? 4 : 0)
                              + (m_ovf ? 2 : 0) + (m_go ? 1 : 0));
                else if (idx == 2 && rxn > 0) begin
                    nrd  = 16'(rx_q[0]);
                    rpop = 1;
                end else if (idx == 3)
                    nrd = 16'(rxn * 16 + (m_errf ? 8 : 0) + (m_eop ? 4 : 0)
                              + (m_rovf ? 2 : 0) + (rxn > 0 ? 1 : 0));
            end
        end

        tpush = 0; setgo = 0; n_ovf = m_ovf;
        if (wr && sel && idx == 0) begin
            if (txn == DEPTH) n_ovf = 1;
            else tpush = 1;
        end
        if (wr && sel && idx == 1) begin
            if (wd[1]) n_ovf = 0;
            if (wd[0] && txn > 0) setgo = 1;
        end
        n_go = setgo || (m_go && !(tpop && tlast));

        n_rovf = m_rovf; n_eop = m_eop; n_errf = m_errf;
        if (wr && sel && idx == 3) begin
            if (wd[1]) n_rovf = 0;
            if (wd[2]) n_eop = 0;
            if (wd[3]) n_errf = 0;
        end
        rpush = rxv && (rxn < DEPTH || rpop);
        if (rxv && !rpush) n_rovf = 1;
        if (eop) n_eop = 1;
        if (err) n_errf = 1;

        @(posedge clk);
        #1;
        if (tpop) void'(tx_q.pop_front());
        if (tpush) tx_q.push_back(wd[7:0]);
        if (rpop) void'(rx_q.pop_front());
        if (rpush) rx_q.push_back(rxd);
        m_go = n_go; m_ovf = n_ovf; m_rovf = n_rovf; m_eop = n_eop; m_errf = n_errf;
        m_rdata = nrd;
        check_eq("io_rdata", io_rdata, m_rdata);

        io_rd = 0; io_wr = 0; rx_valid = 0; rx_eop = 0; rx_err = 0;
    endtask

    task automatic cpu_wr(input logic [15:0] a, input logic [15:0] d);
        step(a, 1'b0, 1'b1, d, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic cpu_rd(input logic [15:0] a);
        step(a, 1'b1, 1'b0, 16'h0000, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic idle(input logic rdy);
        step(16'h0000, 1'b0, 1'b0, 16'h0000, rdy, 8'h00, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic rx_push(input logic [7:0] d);
        step(16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, d, 1'b1, 1'b0, 1'b0);
    endtask

    // Reset in the middle of the high clock phase, away from any edge.
    task automatic pulse_reset();
        #2;
        reset = 1'b1;
        #1;
        check_eq("rst_tx_valid", 16'(tx_valid), 16'h0000);
        check_eq("rst_io_rdata", io_rdata, 16'h0000);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        io_addr = 0; io_rd = 0; io_wr = 0; io_wdata = 0;
        tx_ready = 0; rx_data = 0; rx_valid = 0; rx_eop = 0; rx_err = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_eq("reset_io_rdata", io_rdata, 16'h0000);
        check_eq("reset_tx_valid", 16'(tx_valid), 16'h0000);
        check_eq("reset_tx_last", 16'(tx_last), 16'h0000);
        check_eq("reset_tx_data", 16'(tx_data), 16'h0000);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // TX packet
        cpu_wr(16'h6000, 16'h0011);
        cpu_wr(16'h6000, 16'h0022);
        cpu_wr(16'h6000, 16'h0033);
        cpu_wr(16'h6002, 16'h0001);
        check_eq("pkt_b0", 16'(tx_data), 16'h0011);
        check_eq("pkt_l0", 16'(tx_last), 16'h0000);
        idle(1'b1);
        check_eq("pkt_b1", 16'(tx_data), 16'h0022);
        check_eq("pkt_l1", 16'(tx_last), 16'h0000);
        idle(1'b1);
        check_eq("pkt_b2", 16'(tx_data), 16'h0033);
        check_eq("pkt_l2", 16'(tx_last), 16'h0001);
        idle(1'b1);
        check_eq("pkt_done", 16'(tx_valid), 16'h0000);
        cpu_rd(16'h6002);
        check_eq("pkt_status", io_rdata, 16'h0008);

        // TX overflow
        pulse_reset();
        for (int i = 0; i < 5; i++) cpu_wr(16'h6000, 16'(8'h41 + i));
        cpu_rd(16'h6002);
        check_eq("ovf_status", io_rdata, 16'h0046);
        cpu_wr(16'h6002, 16'h0002);
        cpu_rd(16'h6002);
        check_eq("ovf_cleared", io_rdata, 16'h0044);
        cpu_wr(16'h6002, 16'h0001);
        for (int i = 0; i < 4; i++) begin
            check_eq("ovf_byte", 16'(tx_data), 16'(8'h41 + i));
            idle(1'b1);
        end
        check_eq("ovf_no_fifth", 16'(tx_valid), 16'h0000);

        // RX stream
        pulse_reset();
        rx_push(8'hA5);
        rx_push(8'h5A);
        step(16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        cpu_rd(16'h6004);
        check_eq("rx_first", io_rdata, 16'h00A5);
        cpu_rd(16'h6004);
        check_eq("rx_second", io_rdata, 16'h005A);
        cpu_rd(16'h6006);
        check_eq("rx_status", io_rdata, 16'h0004);
        cpu_rd(16'h6004);
        check_eq("rx_empty_read", io_rdata, 16'h0000);

        // RX full edge
        pulse_reset();
        for (int i = 1; i <= 4; i++) rx_push(8'(i));
        step(16'h6004, 1'b1, 1'b0, 16'h0000, 1'b0, 8'h05, 1'b1, 1'b0, 1'b0);
        check_eq("full_rd_head", io_rdata, 16'h0001);
        cpu_rd(16'h6006);
        check_eq("full_no_rovf", io_rdata, 16'h0041);
        rx_push(8'h06);
        cpu_rd(16'h6006);
        check_eq("full_rovf", io_rdata, 16'h0043);
        for (int i = 2; i <= 5; i++) begin
            cpu_rd(16'h6004);
            check_eq("full_order", io_rdata, 16'(i));
        end

        // Flag clear race
        pulse_reset();
        step(16'h6006, 1'b0, 1'b1, 16'h0008, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        cpu_rd(16'h6006);
        check_eq("race_err_kept", io_rdata, 16'h0008);
        cpu_wr(16'h6006, 16'h0008);
        cpu_rd(16'h6006);
        check_eq("err_cleared", io_rdata, 16'h0000);

        // Reset mid-packet
        cpu_wr(16'h6000, 16'h0077);
        cpu_wr(16'h6000, 16'h0088);
        cpu_wr(16'h6002, 16'h0001);
        cpu_rd(16'h6002);
        check_eq("pre_rst_valid", 16'(tx_valid), 16'h0001);
        check_eq("pre_rst_rdata", io_rdata, 16'h0021);
        pulse_reset();
        cpu_rd(16'h6002);
        check_eq("post_rst_tx", io_rdata, 16'h0008);
        cpu_rd(16'h6006);
        check_eq("post_rst_rx", io_rdata, 16'h0000);
        idle(1'b1);
        check_eq("post_rst_quiet", 16'(tx_valid), 16'h0000);

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            logic [15:0] a, d;
            logic rd, wr;
            int op;
            a  = addr_tab[$urandom_range(0, 9)];
            d  = 16'($urandom);
            op = $urandom_range(0, 9);
            rd = (op >= 3 && op <= 6);
            wr = (op <= 2 || op == 6);
            step(a, rd, wr, d, 1'($urandom_range(0, 1)), 8'($urandom),
                 ($urandom_range(0, 2) == 0), ($urandom_range(0, 9) == 0),
                 ($urandom_range(0, 9) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/usb_sie_regs.md
Name: usb_sie_regs

Overview:
CPU-side register block for the USB serial interface engine, decoded at SIE base 16'h6000 with offsets TX_DATA 0x000, TX_CONTROL 0x002, RX_DATA 0x004 and RX_CONTROL 0x006.
- Sits between the 16-bit I/O bus and the SIE byte streams.
- Buffers transmit bytes in a TX FIFO and hands them to the SIE with valid/ready and a last-byte marker.
- Buffers received bytes in an RX FIFO with sticky end-of-packet, error and overflow flags.

Parameters:
- DEPTH, 4: entries per FIFO; power of two, at least 2.
- AW, 2: log2(DEPTH).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- io_addr  in  16  CPU byte address
- io_rd  in  1  read strobe, one cycle
- io_wr  in  1  write strobe, one cycle
- io_wdata  in  16  write data
- io_rdata  out  16  read data, registered
- tx_data  out  8  byte to SIE
- tx_valid  out  1  tx_data valid
- tx_last  out  1  current byte is last of packet
- tx_ready  in  1  SIE accepts byte this cycle
- rx_data  in  8  byte from SIE
- rx_valid  in  1  rx_data strobe
- rx_eop  in  1  end-of-packet pulse from SIE
- rx_err  in  1  PID/CRC/bit-stuff error pulse from SIE

Behaviour:
- Reset values: io_rdata=0, tx_valid=0, tx_last=0, tx_data=0. Both FIFOs empty; go, ovf, eop and err flags cleared.
- Decode:
  - Selected when io_addr[15:12]==4'h6. Register is chosen by io_addr[11:1]; io_addr[0] is ignored.
  - Unmapped offsets: reads return 0, writes are ignored.
  - io_rd and io_wr together is illegal; the write takes precedence.
- Read latency: io_rdata is valid exactly 1 cycle after io_rd. io_rdata holds its value until the next read.
- TX_DATA write: pushes io_wdata[7:0] into the TX FIFO.
  - If the FIFO is full, the write is dropped and the ovf flag is set.
- TX_DATA read: returns 0.
- TX_CONTROL write:
  - Bit0=1 sets go, but only if the FIFO is non-empty.
  - Bit1=1 clears the ovf flag.
  - Bit0=1 with the FIFO empty is ignored.
- TX_CONTROL read:
  - [0] go (busy)
  - [1] ovf
  - [2] full
  - [3] empty
  - [AW+4:4] count
- TX stream:
  - tx_valid = go & ~empty.
  - tx_data = FIFO head.
  - tx_last = tx_valid & (count==1).
  - A pop happens when tx_valid & tx_ready.
  - A pop with tx_last clears go in the same edge.
  - CPU pushes while go is set are accepted and extend the packet.
- RX FIFO:
  - rx_valid pushes rx_data.
  - When full, the byte is dropped and the rovf flag is set.
  - rx_eop sets the eop flag; rx_err sets the err flag. Both pulses in one cycle set both flags.
- RX_DATA read:
  - io_rdata = {8'h00, head}, and the FIFO pops on the same edge.
  - Empty read returns 0 with no pop.
  - A same-cycle push and pop is allowed, including when full: count is unchanged and nothing is dropped.
- RX_CONTROL read:
  - [0] not-empty
  - [1] rovf
  - [2] eop
  - [3] err
  - [AW+4:4] count
- RX_CONTROL write: each 1 in bits[3:1] clears the matching flag. A set and a clear in the same cycle leaves the flag set.
- FIFO pointers: AW-bit pointers that wrap modulo DEPTH, plus a separate count register of width AW+1.
- Reset asserted mid-packet: everything clears asynchronously. tx_valid drops immediately and no byte is repeated after reset.

Decomposition:
- Extend the existing I/O address package with typedefs for the TX_CONTROL and RX_CONTROL bit layouts (packed structs) and with the bit-index constants.
- One natural sub-module, usb_byte_fifo, instantiated twice. It is parameterized on DEPTH and provides push, pop, full, empty and count.
- Decode logic, flags and read mux stay in usb_sie_regs.

Test Plan:
- TX packet:
  - Stimulus: write 0x11, 0x22, 0x33 to 16'h6000, write 0x0001 to 16'h6002, hold tx_ready=1.
  - Required: tx_data is 11, 22, 33 on consecutive cycles; tx_last only on 33; a TX_CONTROL read afterwards returns busy=0, empty=1.
- TX overflow:
  - Stimulus: 5 writes to TX_DATA with DEPTH=4, then write 0x0002 to TX_CONTROL.
  - Required: count=4 and ovf=1 before the write; ovf=0 after it; the fifth byte is never transmitted.
- RX stream:
  - Stimulus: push A5, 5A with rx_valid, pulse rx_eop, then read 16'h6004 twice.
  - Required: io_rdata is 0x00A5 then 0x005A, each one cycle after io_rd; RX_CONTROL reads 0x0004.
- RX full edge:
  - Stimulus: fill 4 bytes, then apply rx_valid and a RX_DATA read in the same cycle.
  - Required: no rovf; count stays 4; read order is preserved.
  - Stimulus: a further push with no read.
  - Required: rovf=1.
- Flag clear race:
  - Stimulus: rx_err pulses in the same cycle as a write of 0x0008 to RX_CONTROL.
  - Required: err remains 1.
- Reset mid-packet:
  - Stimulus: assert reset while tx_valid=1 with tx_ready=0.
  - Required: tx_valid=0 and io_rdata=0 without waiting for a clock edge; status reads after reset return empty and all flags clear.
